// File: rtl/decoder8b_pulse_if.sv
// ---------------------------------------------------------------------------
// decoder8b_pulse_if
// Bus bundle for the pulse-stretching 3-to-8 decoder.
//   data_in  [2:0] : code offered by the upstream encoder
//   valid_in       : data_in is valid
//   ready          : decoder can take a code this cycle
//   data_out [7:0] : one-hot pulse output (0 when idle or in a gap)
//   busy           : decoder is pulsing or inserting a gap
// master = upstream/observer side, slave = decoder side.
// ---------------------------------------------------------------------------
interface decoder8b_pulse_if;
    logic [2:0] data_in;
    logic       valid_in;
    logic       ready;
    logic [7:0] data_out;
    logic       busy;

    modport master (
        output data_in,
        output valid_in,
        input  ready,
        input  data_out,
        input  busy
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready,
        output data_out,
        output busy
    );
endinterface

// File: rtl/decoder8b_pulse.sv
// ---------------------------------------------------------------------------
// decoder8b_pulse
// Registered 3-to-8 decoder with pulse stretching. Each accepted code drives
// its one-hot line for PULSE_LEN cycles, followed by GAP_LEN all-zero cycles.
// A single-entry buffer holds one pending code so back-to-back codes from the
// upstream encoder are not lost.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : slave side of decoder8b_pulse_if
//          (data_in, valid_in, ready, data_out, busy)
// ---------------------------------------------------------------------------
module decoder8b_pulse #(
    parameter int PULSE_LEN = 4,   // 1..255
    parameter int GAP_LEN   = 1    // 0..255
) (
    input  logic             clk,
    input  logic             rst,
    decoder8b_pulse_if.slave bus
);

    localparam logic [7:0] PULSE_RLD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_RLD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] out_q, out_n;
    logic       buf_full, buf_full_n;
    logic [2:0] buf_code, buf_code_n;
    logic       busy_q;
    logic       xfer;
    logic       have_src;
    logic [2:0] src_code;

    function automatic logic [7:0] decode(input logic [2:0] code);
        return 8'b1 << code;
    endfunction

    assign bus.ready    = !rst && !buf_full;
    assign bus.data_out = out_q;
    assign bus.busy     = busy_q;

    assign xfer = bus.valid_in && bus.ready;

    // At an expiry edge the buffered code has priority; a same-edge transfer
    // can only happen when the buffer is empty because ready is low otherwise.
    assign have_src = buf_full || xfer;
    assign src_code = buf_full ? buf_code : bus.data_in;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        out_n      = out_q;
        buf_full_n = buf_full;
        buf_code_n = buf_code;

        case (state)
            IDLE: begin
                if (xfer) begin
                    state_n = ACTIVE;
                    out_n   = decode(bus.data_in);
                    cnt_n   = PULSE_RLD;
                end
            end

            ACTIVE: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                    if (xfer) begin
                        buf_full_n = 1'b1;
                        buf_code_n = bus.data_in;
                    end
                end else if (GAP_LEN > 0) begin
                    state_n = GAP;
                    out_n   = 8'h00;
                    cnt_n   = GAP_RLD;
                    if (xfer) begin
                        buf_full_n = 1'b1;
                        buf_code_n = bus.data_in;
                    end
                end else if (have_src) begin
                    // zero-gap bypass: next pulse starts on the expiry edge
                    state_n    = ACTIVE;
                    out_n      = decode(src_code);
                    cnt_n      = PULSE_RLD;
                    buf_full_n = 1'b0;
                end else begin
                    state_n = IDLE;
                    out_n   = 8'h00;
                end
            end

            GAP: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                    if (xfer) begin
                        buf_full_n = 1'b1;
                        buf_code_n = bus.data_in;
                    end
                end else if (have_src) begin
                    state_n    = ACTIVE;
                    out_n      = decode(src_code);
                    cnt_n      = PULSE_RLD;
                    buf_full_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                out_n   = 8'h00;
                cnt_n   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            out_q    <= 8'h00;
            buf_full <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            out_q    <= out_n;
            buf_full <= buf_full_n;
            busy_q   <= (state_n != IDLE);
        end
    end

    // Pending code storage; only meaningful while buf_full is set.
    always_ff @(posedge clk) begin
        buf_code <= buf_code_n;
    end

endmodule

// File: doc/decoder8b_pulse.md
# decoder8b_pulse

Registered 3-to-8 decoder with pulse stretching, the output side of the 8-bit priority-encoder path. It accepts a 3-bit code through a valid/ready handshake and drives the matching one-hot line on `data_out` for `PULSE_LEN` cycles. It then inserts `GAP_LEN` all-zero cycles before the next code. A single-entry buffer holds one pending code, so an upstream encoder can hand over back-to-back codes without loss.

## Interface
- `PULSE_LEN`, default 4: cycles each one-hot output is held. Legal range 1..255.
- `GAP_LEN`, default 1: all-zero cycles after each pulse. Legal range 0..255.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `data_in`  input  3: code to decode; sampled only on transfer.
- `valid_in`  input  1: `data_in` is valid.
- `ready`  output  1: block can accept a code. Combinational, equal to `!rst && !buf_full`.
- `data_out`  output  8: registered one-hot output, `8'h00` when no pulse is active.
- `busy`  output  1: registered, 1 when state is not IDLE.

## Operation
- Transfer: occurs on a rising edge where `valid_in && ready` is true. Transfers are ignored while `rst` is high.
- Decode: `data_out = 8'b1 << code`. Code 0 maps to `8'h01`; code 7 maps to `8'h80`.
- States: IDLE, ACTIVE, GAP.
- Counter `cnt`: 8 bits.
- Buffer: one entry, made of `buf_code[2:0]` and `buf_full`.
- Next source, evaluated at an expiry edge: `buf_code` if `buf_full`; otherwise `data_in` if a transfer occurs on that same edge; otherwise none.
- Load of a source: state goes to ACTIVE, `data_out` takes the decoded source, `cnt` is set to `PULSE_LEN-1`, and `buf_full` is cleared if the buffer was the source.
- IDLE: buffer is always empty. A transfer loads `data_in` directly.
- ACTIVE, `cnt != 0`: decrement `cnt`. A transfer writes the buffer (`buf_full` goes to 1).
- ACTIVE, `cnt == 0` (expiry edge):
  - If `GAP_LEN > 0`: go to GAP, `data_out` goes to 0, `cnt` is set to `GAP_LEN-1`. A transfer on this edge writes the buffer.
  - If `GAP_LEN == 0`: load the next source. With no source, go to IDLE and `data_out` goes to 0.
- GAP, `cnt != 0`: decrement `cnt`. A transfer writes the buffer.
- GAP, `cnt == 0` (expiry edge): load the next source. With no source, go to IDLE.
- Buffer full: `ready` is 0. No transfer can coincide with a buffer drain, so there is no write/read conflict.
- Code loss and duplication are forbidden. Every transferred code produces exactly one pulse, in transfer order.
- Reset, including mid-operation:
  - State goes to IDLE.
  - `data_out` goes to `8'h00`.
  - `busy` goes to 0.
  - `buf_full` goes to 0; any pending code is discarded.
  - `cnt` goes to 0.
  - `ready` is 0 while `rst` is high and 1 after release.

## Timing
- Cycle T is the clock period following transfer edge T.
- Latency: a code accepted from IDLE appears on `data_out` in cycle T, one edge after it was presented.
- Pulse: `data_out` is non-zero in cycles T..T+PULSE_LEN-1.
- Gap: zero in cycles T+PULSE_LEN..T+PULSE_LEN+GAP_LEN-1.
- Back-to-back pulse: a buffered code, or a code accepted on the final gap edge, starts at cycle T+PULSE_LEN+GAP_LEN with no extra bubble.
- `busy` covers both ACTIVE and GAP. It falls to 0 in the first IDLE cycle.
- `ready` goes low in the cycle after a buffer write. It returns high in the cycle after the buffer drains.

## Test plan
- Reset: hold `rst` for 3 cycles. Require `data_out=8'h00`, `busy=0`, and `ready=0`. After release, require `ready=1` and no output activity with `valid_in=0`.
- Single code (PULSE_LEN=4, GAP_LEN=1): accept 3'd5 at edge T. Require:
  - `data_out=8'h20` in cycles T..T+3;
  - `data_out=8'h00` from T+4;
  - `busy=1` in cycles T..T+4 and 0 from T+5.
- Back-to-back (4/1): accept 3'd0 at T and 3'd7 at T+1. Require:
  - `ready=0` in cycles T+1..T+4 and 1 from T+5;
  - `data_out=8'h01` in T..T+3, `8'h00` in T+4, `8'h80` in T+5..T+8, `8'h00` from T+9;
  - IDLE from T+10.
- Bypass (PULSE_LEN=4, GAP_LEN=0): accept 3'd2 at T, keep `valid_in=0` during T..T+2, then present 3'd4 at edge T+4. Require `data_out=8'h04` in T..T+3 and `8'h10` in T+4..T+7, with no zero cycle in between.
- Stream under backpressure (4/1): hold `valid_in=1`, update codes 3, 1, 6 only after each transfer. Require pulses `8'h08`, `8'h02`, `8'h40` in that order, each 4 cycles long and separated by 1 zero cycle.
- Reset mid-operation: assert `rst` asynchronously in cycle T+2 of a 3'd3 pulse while the buffer holds 3'd6. Require `data_out=8'h00` immediately and `busy=0`. After release, no `8'h40` pulse appears.
